// File: rtl/othello_pkg.sv
// Shared Othello definitions: cell encodings, board type, cursor FSM states
// and the key indices used by the player-input front end.
package othello_pkg;

  localparam logic [1:0] WHITE = 2'd0;
  localparam logic [1:0] BLACK = 2'd1;
  localparam logic [1:0] EMPTY = 2'd2;

  typedef logic [0:7][0:7][1:0] board_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_HOLD
  } cursor_state_e;

  localparam int KEY_UP    = 0;
  localparam int KEY_DOWN  = 1;
  localparam int KEY_LEFT  = 2;
  localparam int KEY_RIGHT = 3;
  localparam int KEY_OK    = 4;
  localparam int NUM_KEYS  = 5;

  localparam logic [2:0] ROW_RST = 3'd2;
  localparam logic [2:0] COL_RST = 3'd3;

  // Opposing presses cancel; 3-bit arithmetic gives the board wrap for free.
  function automatic logic [2:0] step_pos(input logic [2:0] pos,
                                          input logic       inc,
                                          input logic       dec);
    if (inc && !dec) begin
      return pos + 3'd1;
    end else if (dec && !inc) begin
      return pos - 3'd1;
    end else begin
      return pos;
    end
  endfunction

endpackage

// File: rtl/cursor_ctrl_key_debounce.sv
// One push-button: 2-FF synchronizer, stable-level debounce counter and a
// registered one-cycle pulse on each rising edge of the debounced level.
module key_debounce #(
  parameter int DB_CYC = 500000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_press
);

  localparam int CW = $clog2(DB_CYC + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q,  level_d;
  logic          level_prev_q;
  logic          press_q,  press_d;
  logic [CW-1:0] cnt_q,    cnt_d;

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    // Any sample agreeing with the debounced level restarts the count.
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DB_CYC - 1)) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = level_q & ~level_prev_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= i_raw;
      sync2_q      <= sync1_q;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= press_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_press = press_q;

endmodule

// File: rtl/cursor_ctrl.sv
// Othello player-input front end: conditioned keys move an 8x8 wrap-around
// cursor, OK commits an empty square once per enable window, cursor blinks.
module cursor_ctrl
  import othello_pkg::*;
#(
  parameter int DB_CYC    = 500000,
  parameter int BLINK_CYC = 12500000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_key_up,
  input  logic       i_key_down,
  input  logic       i_key_left,
  input  logic       i_key_right,
  input  logic       i_key_ok,
  input  logic       i_enable,
  input  board_t     i_board,
  output logic [2:0] o_row,
  output logic [2:0] o_col,
  output logic       o_player_done,
  output logic       o_reject,
  output logic       o_cursor_vis
);

  localparam int BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] press;

  assign key_raw = {i_key_ok, i_key_right, i_key_left, i_key_down, i_key_up};

  generate
    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      key_debounce #(.DB_CYC(DB_CYC)) u_key (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_raw   (key_raw[gi]),
        .o_press (press[gi])
      );
    end
  endgenerate

  cursor_state_e state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [2:0]    col_q, col_d;
  logic          done_q, done_d;
  logic          reject_q, reject_d;
  logic          vis_q, vis_d;
  logic [BW-1:0] blink_q, blink_d;
  logic [2:0]    row_step, col_step;
  logic          move_en, move_applied, cell_empty;

  assign cell_empty = (i_board[row_q][col_q] == EMPTY);

  always_comb begin
    state_d  = state_q;
    done_d   = 1'b0;
    reject_d = 1'b0;
    move_en  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        move_en = 1'b1;
        if (i_enable) state_d = S_ARMED;
      end
      S_ARMED: begin
        // Enable loss wins over OK; an acted-on OK swallows any same-cycle move.
        if (!i_enable) begin
          state_d = S_IDLE;
          move_en = 1'b1;
        end else if (press[KEY_OK]) begin
          if (cell_empty) begin
            done_d  = 1'b1;
            state_d = S_HOLD;
          end else begin
            reject_d = 1'b1;
          end
        end else begin
          move_en = 1'b1;
        end
      end
      S_HOLD: begin
        if (!i_enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    row_step     = step_pos(row_q, press[KEY_DOWN],  press[KEY_UP]);
    col_step     = step_pos(col_q, press[KEY_RIGHT], press[KEY_LEFT]);
    move_applied = move_en && ((row_step != row_q) || (col_step != col_q));
    row_d        = move_en ? row_step : row_q;
    col_d        = move_en ? col_step : col_q;

    vis_d = vis_q;
    if (move_applied) begin
      blink_d = '0;
      vis_d   = 1'b1;
    end else if (blink_q == BW'(BLINK_CYC - 1)) begin
      blink_d = '0;
      vis_d   = ~vis_q;
    end else begin
      blink_d = blink_q + BW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      row_q    <= ROW_RST;
      col_q    <= COL_RST;
      done_q   <= 1'b0;
      reject_q <= 1'b0;
      vis_q    <= 1'b1;
      blink_q  <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      col_q    <= col_d;
      done_q   <= done_d;
      reject_q <= reject_d;
      vis_q    <= vis_d;
      blink_q  <= blink_d;
    end
  end

  assign o_row         = row_q;
  assign o_col         = col_q;
  assign o_player_done = done_q;
  assign o_reject      = reject_q;
  assign o_cursor_vis  = vis_q;

endmodule

// File: doc/cursor_ctrl.md
# cursor_ctrl

Player-input front end for the Othello game. Conditions five raw push-buttons (synchronize, debounce, edge-detect), maintains an 8x8 board cursor with wrap-around, and issues the one-cycle commit pulse plus held row/col that the game controller samples during the human player's turn. Sits directly upstream of the controller: its outputs drive the controller's player row, column and done inputs. It consumes the controller's board output to reject commits on occupied squares.

## Interface
Parameters:
- DB_CYC, 500000: consecutive stable cycles before a debounced key level changes (10 ms at 50 MHz).
- BLINK_CYC, 12500000: cycles per half-period of the cursor blink.

Ports:
- i_clk  in  1  system clock; single clock domain.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_key_up, i_key_down, i_key_left, i_key_right, i_key_ok  in  1 each  raw buttons, active-high, asynchronous to i_clk.
- i_enable  in  1  high while the controller awaits a human move.
- i_board  in  2 x [0:7][0:7]  current board; 0 white, 1 black, 2 empty.
- o_row  out  3  cursor row; reset 2.
- o_col  out  3  cursor column; reset 3.
- o_player_done  out  1  one-cycle commit pulse; reset 0.
- o_reject  out  1  one-cycle pulse on OK over an occupied square; reset 0.
- o_cursor_vis  out  1  blink phase for the display; reset 1.

## Operation
Key conditioning (per key, identical):
- 2-FF synchronizer, then a debounce counter.
- The counter counts while the synchronized level differs from the debounced level, and clears when they are equal.
- On reaching DB_CYC the debounced level flips and the counter clears.
- Press = registered rising edge of the debounced level. Releases produce nothing. There is no auto-repeat.

Cursor:
- up: row-1. down: row+1. left: col-1. right: col+1.
- Arithmetic is 3-bit modulo 8: 0-1 wraps to 7, 7+1 wraps to 0.
- up and down pressed in the same cycle: row unchanged. left and right likewise for col.
- A row move and a col move in the same cycle both apply.

State machine:
- S_IDLE: i_enable low. Moves are accepted. OK is ignored, with no reject. Enter S_ARMED when i_enable is high.
- S_ARMED:
  - Moves are accepted.
  - OK press with i_board[o_row][o_col]==2: pulse o_player_done and go to S_HOLD.
  - OK press on a non-empty cell: pulse o_reject and stay.
  - OK and a move in the same cycle: the OK applies to the pre-move position and the move is discarded.
  - i_enable low: go to S_IDLE.
- S_HOLD:
  - o_row/o_col are frozen and all presses are discarded, because the controller reads row/col through its update phase.
  - Return to S_IDLE when i_enable is low.
  - This guarantees at most one commit per enable window.
  - A rejected move (no flips) returns the controller to its player state only after i_enable has dropped, so S_IDLE → S_ARMED re-arms.

Blink:
- Counter wraps at BLINK_CYC-1 and toggles o_cursor_vis.
- Any applied move clears the counter and forces o_cursor_vis=1.

Reset (any time, including mid-debounce or in S_HOLD):
- All counters, synchronizers and debounced levels go to 0.
- State goes to S_IDLE, and outputs take their reset values.

## Timing
- Raw key rises clean between edges E0 and E1 (first sampled at E1): debounced level rises at E(DB_CYC+2) and the press registers at E(DB_CYC+3).
- o_row/o_col/o_player_done/o_reject update at E(DB_CYC+4).
- o_player_done and o_reject are exactly one cycle wide and are registered outputs.
- o_row/o_col are valid in the same cycle as o_player_done and stable until the block leaves S_HOLD.
- i_enable falling in the same cycle as an OK press: the commit is dropped and the state goes to S_IDLE.
- A bounce shorter than DB_CYC cycles produces no press.

## Structure
- Shared package othello_pkg holds:
  - WHITE=0, BLACK=1, EMPTY=2;
  - board_t (2-bit [0:7][0:7]);
  - the cursor state enum.
- Sub-module key_debounce (synchronizer + debounce counter + press pulse), instantiated five times with parameter DB_CYC.
- Target 150–250 lines total.

## Test plan
Run with DB_CYC=4 and BLINK_CYC=8.
1. Reset then a single clean down press: o_row 2→3 at exactly E8 after first sampling; o_col stays 3.
2. From row 0 press up: o_row=7. From col 7 press right: o_col=0. Up+down together from row 5: o_row stays 5.
3. Key bouncing with high pulses of 3 cycles: no cursor change. Then held for 6 cycles: exactly one move.
4. i_enable=1, cursor (2,3) empty, OK press: one-cycle o_player_done with row=2, col=3. A further OK plus left press while enable stays high: no pulse and cursor unchanged. Drop enable then raise it: a new OK commits again.
5. Cursor on (3,3)=WHITE with OK press: o_reject for 1 cycle and no o_player_done. With i_enable=0, OK gives neither pulse.
6. Assert i_rst_n=0 mid-debounce and while in S_HOLD: outputs return to (2,3,0,0,1) and the pending press is never issued after release.
